// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 controller, message expansion and compression:
// state codes decoded by ME/MC, block geometry and the initial hash values.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_PREP = 3'b010,
        ST_COMP = 3'b011,
        ST_OUT  = 3'b100
    } state_e;

    localparam int NUM_MSG_WORDS    = 16;
    localparam int NUM_ROUNDS       = 64;
    localparam int NUM_DIGEST_WORDS = 8;

    function automatic logic [31:0] h_init(input logic [2:0] idx);
        case (idx)
            3'd0:    h_init = 32'h6a09e667;
            3'd1:    h_init = 32'hbb67ae85;
            3'd2:    h_init = 32'h3c6ef372;
            3'd3:    h_init = 32'ha54ff53a;
            3'd4:    h_init = 32'h510e527f;
            3'd5:    h_init = 32'h9b05688c;
            3'd6:    h_init = 32'h1f83d9ab;
            default: h_init = 32'h5be0cd19;
        endcase
    endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Word/round/digest index counter with clear, load, enable and a terminal-count flag.
// Clear has priority over load, load over enable.
module sha256_round_cnt
    import sha256_pkg::*;
#(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] tc_val_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 tc_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_val_i);

    // The sequencer always clears at a terminal count, so the index never passes the last round.
    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_WIDTH'(NUM_ROUNDS - 1));

endmodule

// File: rtl/sha256_core_ctrl.sv
// SHA-256 top-level sequencer: LOAD 16 words, PREP, 64 COMP rounds, stream 8 digest words.
// Optional perf counters are built when SHA256_CTRL_PERF_EN is defined.
module sha256_core_ctrl
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic                  msg_valid_in,
    input  logic [DATA_WIDTH-1:0] msg_data_in,
    output logic                  msg_ready_out,
    output logic [DATA_WIDTH-1:0] me_data_out,
    output logic                  me_we_out,
    output logic [2:0]            FSM_core_out,
    output logic [CNT_WIDTH-1:0]  core_count_out,
    input  logic [DATA_WIDTH-1:0] mc_data_in,
    output logic                  dig_valid_out,
    input  logic                  dig_ready_in,
    output logic [DATA_WIDTH-1:0] dig_data_out,
    output logic                  busy_out,
`ifdef SHA256_CTRL_PERF_EN
    output logic [15:0]           perf_blocks_out,
    output logic [15:0]           perf_stall_out,
`endif
    output logic                  done_out
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] me_data_q, me_data_d;
    logic                  me_we_q, me_we_d;
    logic                  done_q, done_d;
    logic                  cnt_clr, cnt_en, cnt_tc;
    logic [CNT_WIDTH-1:0]  cnt_tc_val, cnt_value;

    sha256_round_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_round_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .tc_val_i   (cnt_tc_val),
        .count_o    (cnt_value),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d    = state_q;
        me_data_d  = me_data_q;
        me_we_d    = 1'b0;
        done_d     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        cnt_tc_val = CNT_WIDTH'(NUM_MSG_WORDS - 1);

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (start_in) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (msg_valid_in) begin
                    me_data_d = msg_data_in;
                    me_we_d   = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_PREP;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_PREP: begin
                cnt_clr = 1'b1;
                state_d = abort_in ? ST_IDLE : ST_COMP;
            end
            ST_COMP: begin
                cnt_tc_val = CNT_WIDTH'(NUM_ROUNDS - 1);
                if (abort_in) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    state_d = ST_OUT;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_OUT: begin
                cnt_tc_val = CNT_WIDTH'(NUM_DIGEST_WORDS - 1);
                // Abort outranks the final handshake, so no done pulse follows it.
                if (abort_in) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (dig_ready_in) begin
                    if (cnt_tc) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            me_data_q <= '0;
            me_we_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            me_data_q <= me_data_d;
            me_we_q   <= me_we_d;
            done_q    <= done_d;
        end
    end

    assign FSM_core_out   = state_q;
    assign core_count_out = cnt_value;
    assign msg_ready_out  = (state_q == ST_LOAD);
    assign me_data_out    = me_data_q;
    assign me_we_out      = me_we_q;
    assign dig_valid_out  = (state_q == ST_OUT);
    assign dig_data_out   = mc_data_in;
    assign busy_out       = (state_q != ST_IDLE);
    assign done_out       = done_q;

`ifdef SHA256_CTRL_PERF_EN
    logic [15:0] perf_blocks_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (done_q && (perf_blocks_q != 16'hFFFF)) begin
                perf_blocks_q <= perf_blocks_q + 16'd1;
            end
            if ((state_q == ST_OUT) && !dig_ready_in && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_blocks_out = perf_blocks_q;
    assign perf_stall_out  = perf_stall_q;
`endif

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// Self-checking bench for sha256_core_ctrl: random words and digests, cycle-exact phase model,
// input gaps, output backpressure, abort, and mid-block reset.
module tb_sha256_core_ctrl;

    logic        clk = 1'b0;
    logic        rst, start_in, abort_in, msg_valid_in, dig_ready_in;
    logic [31:0] msg_data_in, mc_data_in, me_data_out, dig_data_out;
    logic        msg_ready_out, me_we_out, dig_valid_out, busy_out, done_out;
    logic [2:0]  FSM_core_out;
    logic [6:0]  core_count_out;

    logic [31:0] words [16];
    logic [31:0] digest_mem [8];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    sha256_core_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (start_in),
        .abort_in       (abort_in),
        .msg_valid_in   (msg_valid_in),
        .msg_data_in    (msg_data_in),
        .msg_ready_out  (msg_ready_out),
        .me_data_out    (me_data_out),
        .me_we_out      (me_we_out),
        .FSM_core_out   (FSM_core_out),
        .core_count_out (core_count_out),
        .mc_data_in     (mc_data_in),
        .dig_valid_out  (dig_valid_out),
        .dig_ready_in   (dig_ready_in),
        .dig_data_out   (dig_data_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    // MC model: digest word selected by the index the controller presents.
    assign mc_data_in = digest_mem[core_count_out[2:0]];

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Starts a block and streams 16 random words; returns in the PREP cycle checked, then steps into COMP.
    task automatic load_and_prep(input bit toggle, output int load_cycles, output int pulses);
        int acc = 0;
        bit we_exp = 1'b0;
        bit v;
        load_cycles = 0;
        pulses = 0;
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        while (acc < 16 && load_cycles < 100) begin
            n_tests++; if (FSM_core_out !== 3'b001) begin n_fail++; $display("FAIL load_state cyc=%0d got %b exp 001", load_cycles, FSM_core_out); end
            n_tests++; if (core_count_out !== 7'(acc)) begin n_fail++; $display("FAIL load_count got %0d exp %0d", core_count_out, acc); end
            n_tests++; if (msg_ready_out !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b exp 1", msg_ready_out); end
            n_tests++; if (me_we_out !== we_exp) begin n_fail++; $display("FAIL load_we got %b exp %b", me_we_out, we_exp); end
            if (we_exp) begin
                n_tests++; if (me_data_out !== words[acc-1]) begin n_fail++; $display("FAIL load_data got %h exp %h", me_data_out, words[acc-1]); end
            end
            if (me_we_out === 1'b1) pulses++;
            v = toggle ? (load_cycles % 2 == 1) : 1'b1;
            msg_valid_in = v;
            msg_data_in  = v ? words[acc] : $urandom;
            tick();
            load_cycles++;
            we_exp = v;
            if (v) acc++;
        end
        msg_valid_in = 1'b0;
        n_tests++; if (FSM_core_out !== 3'b010) begin n_fail++; $display("FAIL prep_state got %b exp 010", FSM_core_out); end
        n_tests++; if (core_count_out !== 7'd0) begin n_fail++; $display("FAIL prep_count got %0d exp 0", core_count_out); end
        n_tests++; if (msg_ready_out !== 1'b0) begin n_fail++; $display("FAIL prep_ready got %b exp 0", msg_ready_out); end
        n_tests++; if (me_we_out !== 1'b1 || me_data_out !== words[15]) begin n_fail++; $display("FAIL prep_last_word got we=%b %h exp we=1 %h", me_we_out, me_data_out, words[15]); end
        if (me_we_out === 1'b1) pulses++;
        tick();
    endtask

    // COMP rounds with start/valid noise that must be ignored.
    task automatic run_comp(input int n_rounds);
        for (int r = 0; r < n_rounds; r++) begin
            n_tests++; if (FSM_core_out !== 3'b011) begin n_fail++; $display("FAIL comp_state r=%0d got %b exp 011", r, FSM_core_out); end
            n_tests++; if (core_count_out !== 7'(r)) begin n_fail++; $display("FAIL comp_count got %0d exp %0d", core_count_out, r); end
            n_tests++; if (busy_out !== 1'b1 || dig_valid_out !== 1'b0 || me_we_out !== 1'b0) begin n_fail++; $display("FAIL comp_flags got busy=%b dv=%b we=%b exp 1 0 0", busy_out, dig_valid_out, me_we_out); end
            start_in     = $urandom_range(0, 1);
            msg_valid_in = $urandom_range(0, 1);
            tick();
        end
        start_in     = 1'b0;
        msg_valid_in = 1'b0;
    endtask

    // Streams n_words digest words; when all 8 are taken, checks the done pulse and returns its cycle.
    task automatic drain_output(input int n_words, input int stall_at, input int stall_len,
                                input bit rand_ready, output int done_cyc);
        int rx = 0;
        int stalled = 0;
        int budget = 0;
        done_cyc = -1;
        for (int i = 0; i < 8; i++) digest_mem[i] = $urandom;
        while (rx < n_words && budget < 300) begin
            n_tests++; if (FSM_core_out !== 3'b100 || dig_valid_out !== 1'b1) begin n_fail++; $display("FAIL out_state got %b dv=%b exp 100 dv=1", FSM_core_out, dig_valid_out); end
            n_tests++; if (core_count_out !== 7'(rx)) begin n_fail++; $display("FAIL out_count got %0d exp %0d", core_count_out, rx); end
            n_tests++; if (dig_data_out !== digest_mem[rx]) begin n_fail++; $display("FAIL out_data got %h exp %h", dig_data_out, digest_mem[rx]); end
            n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL out_early_done got %b exp 0", done_out); end
            if (rx == stall_at && stalled < stall_len) begin
                dig_ready_in = 1'b0;
                stalled++;
            end else begin
                dig_ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
            budget++;
            if (dig_ready_in) rx++;
        end
        dig_ready_in = 1'b0;
        n_tests++; if (rx != n_words) begin n_fail++; $display("FAIL out_timeout got %0d words exp %0d", rx, n_words); end
        if (n_words == 8) begin
            done_cyc = cyc;
            n_tests++; if (done_out !== 1'b1) begin n_fail++; $display("FAIL done_pulse got %b exp 1", done_out); end
            n_tests++; if (FSM_core_out !== 3'b000 || core_count_out !== 7'd0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL done_idle got st=%b cnt=%0d busy=%b exp 000 0 0", FSM_core_out, core_count_out, busy_out); end
            tick();
            n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL done_width got %b exp 0", done_out); end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++; if (FSM_core_out !== 3'b000 || core_count_out !== 7'd0) begin n_fail++; $display("FAIL %s_state got %b/%0d exp 000/0", tag, FSM_core_out, core_count_out); end
        n_tests++; if (msg_ready_out !== 1'b0 || me_we_out !== 1'b0) begin n_fail++; $display("FAIL %s_msg got rdy=%b we=%b exp 0 0", tag, msg_ready_out, me_we_out); end
        n_tests++; if (me_data_out !== 32'd0) begin n_fail++; $display("FAIL %s_me_data got %h exp 0", tag, me_data_out); end
        n_tests++; if (dig_valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin n_fail++; $display("FAIL %s_flags got dv=%b busy=%b done=%b exp 0 0 0", tag, dig_valid_out, busy_out, done_out); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        n_tests++; if (FSM_core_out !== 3'b000 || busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_release got %b busy=%b exp 000 0", FSM_core_out, busy_out); end
    endtask

    task automatic test_nominal();
        int c0, lc, pl, dc;
        c0 = cyc;
        load_and_prep(1'b0, lc, pl);
        n_tests++; if (lc != 16) begin n_fail++; $display("FAIL nom_load_len got %0d exp 16", lc); end
        run_comp(64);
        n_tests++; if (cyc - c0 != 82) begin n_fail++; $display("FAIL nom_out_cycle got %0d exp 82", cyc - c0); end
        drain_output(8, -1, 0, 1'b0, dc);
        n_tests++; if (dc - c0 != 90) begin n_fail++; $display("FAIL nom_done_cycle got %0d exp 90", dc - c0); end
    endtask

    task automatic test_gaps();
        int lc, pl, dc;
        load_and_prep(1'b1, lc, pl);
        n_tests++; if (lc != 32) begin n_fail++; $display("FAIL gap_load_len got %0d exp 32", lc); end
        n_tests++; if (pl != 16) begin n_fail++; $display("FAIL gap_we_pulses got %0d exp 16", pl); end
        run_comp(64);
        drain_output(8, -1, 0, 1'b1, dc);
    endtask

    task automatic test_back_to_back_backpressure();
        int lc, pl, dc;
        load_and_prep(1'b0, lc, pl);
        run_comp(64);
        drain_output(8, 3, 10, 1'b1, dc);
    endtask

    task automatic test_abort();
        int lc, pl, dc;
        load_and_prep(1'b0, lc, pl);
        run_comp(20);
        n_tests++; if (core_count_out !== 7'd20) begin n_fail++; $display("FAIL abort_pre_count got %0d exp 20", core_count_out); end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        n_tests++; if (FSM_core_out !== 3'b000 || core_count_out !== 7'd0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL abort_comp got st=%b cnt=%0d busy=%b exp 000 0 0", FSM_core_out, core_count_out, busy_out); end
        n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL abort_comp_done got %b exp 0", done_out); end
        tick();
        n_tests++; if (FSM_core_out !== 3'b000 || done_out !== 1'b0) begin n_fail++; $display("FAIL abort_stay_idle got %b done=%b exp 000 0", FSM_core_out, done_out); end
        // Abort coinciding with the last digest handshake.
        load_and_prep(1'b0, lc, pl);
        run_comp(64);
        drain_output(7, -1, 0, 1'b1, dc);
        abort_in     = 1'b1;
        dig_ready_in = 1'b1;
        tick();
        abort_in     = 1'b0;
        dig_ready_in = 1'b0;
        n_tests++; if (FSM_core_out !== 3'b000 || done_out !== 1'b0) begin n_fail++; $display("FAIL abort_last_hs got %b done=%b exp 000 0", FSM_core_out, done_out); end
        tick();
        n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL abort_last_hs_late_done got %b exp 0", done_out); end
    endtask

    task automatic test_idle_start_abort();
        start_in = 1'b1;
        abort_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_tests++; if (FSM_core_out !== 3'b001) begin n_fail++; $display("FAIL idle_start_abort got %b exp 001", FSM_core_out); end
        tick();
        abort_in = 1'b0;
        n_tests++; if (FSM_core_out !== 3'b000 || core_count_out !== 7'd0) begin n_fail++; $display("FAIL load_abort got %b/%0d exp 000/0", FSM_core_out, core_count_out); end
    endtask

    task automatic test_reset_mid();
        int lc, pl, dc;
        load_and_prep(1'b0, lc, pl);
        run_comp(64);
        drain_output(5, -1, 0, 1'b0, dc);
        n_tests++; if (core_count_out !== 7'd5) begin n_fail++; $display("FAIL midrst_pre_count got %0d exp 5", core_count_out); end
        rst = 1'b1;
        dig_ready_in = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        dig_ready_in = 1'b0;
        tick();
        n_tests++; if (FSM_core_out !== 3'b000 || done_out !== 1'b0) begin n_fail++; $display("FAIL midrst_after got %b done=%b exp 000 0", FSM_core_out, done_out); end
    endtask

    initial begin
        rst          = 1'b1;
        start_in     = 1'b0;
        abort_in     = 1'b0;
        msg_valid_in = 1'b0;
        msg_data_in  = '0;
        dig_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) digest_mem[i] = '0;
        test_reset();
        test_nominal();
        test_gaps();
        test_back_to_back_backpressure();
        test_abort();
        test_nominal();
        test_idle_start_abort();
        test_reset_mid();
        test_nominal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
